tick_arbiter: RTL and testbench
===============================

# tick_arbiter

- Shares one programmable clock-divider timebase among NREQ requesters.
- Each requester asks for a burst of P full output periods at its own half-period threshold.
- The block arbitrates round-robin, drives the divider for the winner, and signals completion.
- It sits between the lab's peripheral controllers and the single slow-clock output (LED/7-seg strobes), so only one owner drives clk_out at a time.

## Interface
- NREQ, 4, number of requesters (2..8)
- CW, 32, threshold/counter width
- clk_in  in  1  system clock (50 MHz on DE2i-150)
- rst  in  1  reset; synchronous, active-low
- req  in  NREQ  per-requester request level; must be held until done
- thresh  in  NREQ*CW  per-requester half-period threshold, slice i = bits [i*CW +: CW]
- periods  in  NREQ*8  per-requester burst length in full output periods, slice i = bits [i*8 +: 8]
- grant  out  NREQ  one-hot current owner, all zero when idle
- busy  out  1  high whenever the state is not IDLE
- done  out  NREQ  one-cycle completion pulse to the owner
- tick  out  1  one-cycle pulse on every clk_out toggle
- clk_out  out  1  divided output, low whenever not in RUN

## Operation
- States are IDLE, LOAD, RUN and DONE.
- **Reset** (rst low at posedge): state = IDLE, grant = 0, done = 0, tick = 0, clk_out = 0, counter = 0, remaining = 0. The round-robin pointer is reset so index 0 has highest priority.
- **IDLE:**
  - If any req bit is set, pick the first set bit at or after pointer+1 (wrapping).
  - Latch that requester's thresh into thresh_l and 2*periods into remaining (9 bits).
  - Set the grant bit and move to LOAD. Pointer = winner.
- **LOAD** (1 cycle): counter = 0 and clk_out = 0.
  - If remaining == 0, go to DONE.
  - Otherwise go to RUN.
- **RUN:**
  - Each cycle: if counter >= thresh_l, then clk_out toggles, tick = 1, counter = 0 and remaining decrements. Otherwise counter increments.
  - When the toggle makes remaining reach 0, go to DONE. clk_out is then low again, because the toggle count is even.
- **DONE** (1 cycle): done[owner] = 1 and grant is still held. Next state is IDLE with grant = 0.
- **Abort:** if req[owner] drops while in LOAD or RUN:
  - Next cycle is IDLE with clk_out = 0, counter = 0, grant = 0.
  - No done pulse is issued.
- **Re-request:** a requester that keeps req high after done re-enters arbitration. Round-robin places it behind any other pending requester.
- **Mid-burst changes:** changes to thresh or periods during a burst are ignored. Values are sampled only in IDLE.
- **Arithmetic:** counter and thresh_l are CW-bit unsigned; the comparison is >=. thresh = 0 gives clk_out = clk_in/2.

## Timing
- Request latency: req set in cycle t (IDLE) gives grant in cycle t+1 (LOAD). RUN starts at t+2.
- Half period is thresh+1 clk_in cycles. The first toggle is visible thresh+1 cycles after RUN entry.
- Burst length: LOAD + 2*P*(thresh+1) RUN cycles, then DONE. Total grant length is 2 + 2*P*(thresh+1) cycles.
- Back-to-back bursts: minimum gap between bursts is one IDLE cycle (grant = 0).
- All outputs are registered.

## Configuration
- **TICK_ARB_SIM_EN defined:** thresh_l is forced to 0 at latch time for every requester, so clk_out = clk_in/2 for fast simulation.
- **TICK_ARB_SIM_EN undefined:** thresh inputs are used as given.
- No other behaviour differs.

## Structure
- **Package tick_arb_pkg:** state encoding (IDLE = 0, LOAD = 1, RUN = 2, DONE = 3) and the defaults for NREQ and CW.
- **Sub-module rr_arbiter:** a combinational round-robin picker. Inputs are req and pointer; outputs are a one-hot winner and its index.
- **Top level:** the FSM, counter, remaining and the output registers.

## Test plan
- **Reset:** hold rst = 0 for 3 cycles with req = 4'b1111. Require grant = 0, busy = 0, clk_out = 0 and done = 0 throughout.
- **Single burst:** req[2] = 1, thresh[2] = 3, periods[2] = 2.
  - Require grant = 4'b0100 on the next cycle.
  - Require 4 tick pulses spaced 4 cycles apart and clk_out high for 4 cycles twice.
  - Require done[2] after 18 grant cycles.
- **Round-robin:** req = 4'b1011 held, all thresh = 0, periods = 1. Require grant order 0, 1, 3, 0.
- **Zero periods:** periods[1] = 0. Require LOAD then DONE: grant for 2 cycles, done[1] = 1, and no tick.
- **Abort:** drop req[0] after its 3rd tick. Require IDLE next cycle, clk_out = 0, no done[0], and the next requester granted.
- **Sim macro:** with TICK_ARB_SIM_EN defined, thresh[0] = 25000000 and periods = 1. Require ticks 1 cycle apart and done after 4 grant cycles.

Source files
------------

// File: rtl/tick_arb_pkg.sv
// Shared state encoding and parameter defaults for the tick arbiter.
package tick_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // A burst of P full periods is 2*P toggles of clk_out.
  function automatic logic [8:0] burst_toggles(input logic [7:0] p);
    return {p, 1'b0};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit strictly after ptr, wrapping.
module rr_arbiter
  import tick_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            win_vld
);

  always_comb begin
    int   idx;
    logic found;
    win     = '0;
    win_idx = '0;
    win_vld = 1'b0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = IW'(idx);
        win_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_arbiter.sv
// Round-robin owner of a shared clock-divider timebase driving clk_out.
// Build option: define TICK_ARB_SIM_EN to force every latched threshold to 0.
//
// state | meaning
// IDLE  | no owner, clk_out low, arbitrating pending requests
// LOAD  | owner granted, counter cleared, burst length checked
// RUN   | dividing clk_in, toggling clk_out at each threshold match
// DONE  | one-cycle completion pulse to the owner, grant still held
module tick_arbiter
  import tick_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] thresh,
  input  logic [NREQ*8-1:0]  periods,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [NREQ-1:0]    done,
  output logic               tick,
  output logic               clk_out
);

  localparam int IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            tick_q, tick_d;
  logic            clk_out_q, clk_out_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   thresh_l_q, thresh_l_d;
  logic [8:0]      rem_q, rem_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   own_q, own_d;

  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic [CW-1:0]   thresh_sel;
  logic [7:0]      periods_sel;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

`ifdef TICK_ARB_SIM_EN
  assign thresh_sel = '0;
`else
  assign thresh_sel = thresh[int'(win_idx)*CW +: CW];
`endif
  assign periods_sel = periods[int'(win_idx)*8 +: 8];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;
    cnt_d      = cnt_q;
    thresh_l_d = thresh_l_q;
    rem_d      = rem_q;
    ptr_d      = ptr_q;
    own_d      = own_q;

    case (state_q)
      ST_IDLE: begin
        grant_d   = '0;
        clk_out_d = 1'b0;
        cnt_d     = '0;
        if (win_vld) begin
          thresh_l_d = thresh_sel;
          rem_d      = burst_toggles(periods_sel);
          grant_d    = win;
          own_d      = win_idx;
          ptr_d      = win_idx;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (!req[own_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rem_d   = '0;
        end else if (rem_q == 9'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins over a coincident toggle so no stray tick escapes.
        if (!req[own_q]) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          clk_out_d = 1'b0;
          cnt_d     = '0;
          rem_d     = '0;
        end else if (cnt_q >= thresh_l_q) begin
          clk_out_d = ~clk_out_q;
          tick_d    = 1'b1;
          cnt_d     = '0;
          rem_d     = rem_q - 9'd1;
          if (rem_q == 9'd1) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        clk_out_d = 1'b0;
        cnt_d     = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        clk_out_d = 1'b0;
        cnt_d     = '0;
        rem_d     = '0;
      end
    endcase

    // done is registered, so it is raised on entry to DONE and lasts exactly that cycle.
    if (state_d == ST_DONE && state_q != ST_DONE) done_d = grant_q;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      thresh_l_q <= '0;
      rem_q      <= '0;
      ptr_q      <= IW'(NREQ - 1);
      own_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      thresh_l_q <= thresh_l_d;
      rem_q      <= rem_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tick_arbiter.sv
// Scoreboard bench for tick_arbiter: directed bursts push expected grant records,
// a negedge monitor pops one per observed grant and checks its whole waveform.
module tb_tick_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 32;

  logic               clk_in = 1'b0;
  logic               rst    = 1'b0;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] thresh;
  logic [NREQ*8-1:0]  periods;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [NREQ-1:0]    done;
  logic               tick;
  logic               clk_out;

  tick_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .req     (req),
    .thresh  (thresh),
    .periods (periods),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .tick    (tick),
    .clk_out (clk_out)
  );

  always #10 clk_in = ~clk_in;

  typedef struct {
    int owner;
    int h;
    int ticks;
    int len;
    int done;
  } rec_t;

  rec_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int eff_thr(input int t);
`ifdef TICK_ARB_SIM_EN
    return 0;
`else
    return t;
`endif
  endfunction

  // Normal burst: LOAD + 2*P*(thr+1) RUN cycles + DONE.
  task automatic push_burst(input int owner, input int thr, input int p);
    rec_t r;
    r.owner = owner;
    r.h     = eff_thr(thr) + 1;
    r.ticks = 2 * p;
    r.len   = 2 + 2 * p * r.h;
    r.done  = 1;
    sb.push_back(r);
  endtask

  task automatic wait_done(input int idx);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk_in); #1;
      if (done[idx]) return;
    end
    chk("wait_done_timeout", 0, 1);
  endtask

  // Monitor
  logic [NREQ-1:0] g_prev;
  bit   active;
  rec_t cur;
  int   off, n_ticks, done_hits, tick_bad, clk_bad, done_bad, busy_bad;

  always @(negedge clk_in) begin
    if (!rst) begin
      g_prev = '0;
      active = 0;
    end else begin
      if (active && grant !== g_prev) begin
        chk("grant_len", off, cur.len);
        chk("tick_count", n_ticks, cur.ticks);
        chk("done_seen", done_hits, cur.done);
        chk("tick_pattern", tick_bad, 0);
        chk("clk_out_shape", clk_bad, 0);
        chk("done_pattern", done_bad, 0);
        chk("busy_in_burst", busy_bad, 0);
        if (grant == '0) chk("idle_outputs", {busy, clk_out, tick, done}, 0);
        active = 0;
      end
      if (grant != '0 && grant !== g_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", grant, 0);
          cur = '{owner: 0, h: 1, ticks: 0, len: 0, done: 0};
        end else begin
          cur = sb.pop_front();
          chk("grant_owner", grant, 1 << cur.owner);
        end
        active = 1; off = 0; n_ticks = 0; done_hits = 0;
        tick_bad = 0; clk_bad = 0; done_bad = 0; busy_bad = 0;
      end
      if (active) begin
        int  k, kc;
        bit  e_tick, e_clk;
        logic [NREQ-1:0] e_done;
        k      = (off >= 1) ? (off - 1) / cur.h : 0;
        kc     = (k < cur.ticks) ? k : cur.ticks;
        e_tick = (off > 1) && ((off - 1) % cur.h == 0) && (k <= cur.ticks);
        e_clk  = (off >= 1) && (kc % 2 == 1);
        e_done = (cur.done != 0 && off == cur.len - 1) ? NREQ'(1 << cur.owner) : '0;
        if (tick !== e_tick) tick_bad++;
        if (clk_out !== e_clk) clk_bad++;
        if (done !== e_done) done_bad++;
        if (busy !== 1'b1) busy_bad++;
        if (tick === 1'b1) n_ticks++;
        if (done === NREQ'(1 << cur.owner)) done_hits++;
        off++;
      end
      g_prev = grant;
    end
  end

  initial begin
    int n;
    rec_t ab;
    req     = '0;
    thresh  = '0;
    periods = '0;

    // Reset held with all requests asserted
    req = 4'b1111;
    repeat (3) begin
      @(negedge clk_in);
      chk("reset_outputs", {grant, busy, clk_out, done}, 0);
    end
    req = '0;
    @(posedge clk_in); #1;
    rst = 1'b1;
    @(posedge clk_in); #1;

    // Round-robin from reset pointer: 0, 1, 3, 0
    thresh  = '0;
    periods = {4{8'd1}};
    push_burst(0, 0, 1);
    push_burst(1, 0, 1);
    push_burst(3, 0, 1);
    push_burst(0, 0, 1);
    req = 4'b1011;
    wait_done(0);
    wait_done(0);
    @(posedge clk_in); #1;
    req = '0;
    repeat (2) @(posedge clk_in); #1;

    // Single burst on requester 2: thresh 3, 2 periods -> 18 grant cycles
    thresh[2*CW +: CW] = 3;
    periods[2*8 +: 8]  = 2;
    push_burst(2, 3, 2);
    req = 4'b0100;
    @(posedge clk_in); #1;
    chk("req_latency", grant, 4'b0100);
    thresh[2*CW +: CW] = 7;
    periods[2*8 +: 8]  = 5;
    wait_done(2);
    @(posedge clk_in); #1;
    req = '0;
    repeat (2) @(posedge clk_in); #1;

    // Zero periods on requester 1: LOAD then DONE, no tick
    thresh[1*CW +: CW] = 5;
    periods[1*8 +: 8]  = 0;
    push_burst(1, 5, 0);
    req = 4'b0010;
    wait_done(1);
    @(posedge clk_in); #1;
    req = '0;
    repeat (2) @(posedge clk_in); #1;

    // Abort requester 0 after its 3rd tick; requester 2 takes over
    thresh[0*CW +: CW] = 1;
    periods[0*8 +: 8]  = 3;
    thresh[2*CW +: CW] = 0;
    periods[2*8 +: 8]  = 1;
    ab.owner = 0;
    ab.h     = eff_thr(1) + 1;
    ab.ticks = 3;
    ab.len   = 3 * ab.h + 3;
    ab.done  = 0;
    sb.push_back(ab);
    push_burst(2, 0, 1);
    req = 4'b0001;
    @(posedge clk_in); #1;
    req[2] = 1'b1;
    n = 0;
    for (int i = 0; i < 500 && n < 3; i++) begin
      @(posedge clk_in); #1;
      if (tick) n++;
    end
    if (n < 3) chk("abort_tick_timeout", n, 3);
    @(posedge clk_in); #1;
    req[0] = 1'b0;
    wait_done(2);
    @(posedge clk_in); #1;
    req = '0;
    repeat (2) @(posedge clk_in); #1;

`ifdef TICK_ARB_SIM_EN
    // Huge threshold collapses to clk_in/2 in the fast-sim build
    thresh[0*CW +: CW] = 25000000;
    periods[0*8 +: 8]  = 1;
    push_burst(0, 25000000, 1);
    req = 4'b0001;
    wait_done(0);
    @(posedge clk_in); #1;
    req = '0;
    repeat (2) @(posedge clk_in); #1;
`endif

    for (int i = 0; i < 50 && (sb.size() != 0 || active); i++) @(posedge clk_in);
    #1;
    chk("scoreboard_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
